// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit queue: FSM state encoding,
// default queue depth and the byte width.
package uart_pkg;

    localparam int TXQ_DEPTH_DEFAULT = 16;
    localparam int BYTE_W            = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } txq_state_t;

endpackage

// File: rtl/uart_txq_fifo.sv
// Synchronous byte FIFO used as the storage for uart_tx_queue.
// A push while full is ignored; fullness is judged before any same-cycle pop.
// A pop while empty is ignored. Pointers wrap modulo DEPTH (power of two).
module uart_txq_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = TXQ_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [AW:0]       o_level
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;

    assign w_full  = (r_count == CNT_FULL);
    assign w_empty = (r_count == CNT_ZERO);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && !w_empty;

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array: written on accepted pushes only, contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and issue sequencer in front of uart_tx.
// Bytes written by the core are buffered; each is handed to the transmitter
// with a one-cycle start pulse, then the frame is waited out by watching
// tx_ready fall and rise again.
// Optional build macro UART_TXQ_OVF_EN adds a sticky overflow flag (ovf)
// with its clear input (ovf_clr); without it, writes while full are
// dropped silently.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH = TXQ_DEPTH_DEFAULT,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              busy,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready
`ifdef UART_TXQ_OVF_EN
    ,
    output logic              ovf,
    input  logic              ovf_clr
`endif
);

    txq_state_t        r_state;
    logic              r_tx_start;
    logic [BYTE_W-1:0] r_tx_data;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [BYTE_W-1:0] w_head;
    logic [AW:0]       w_level;

    // Pop only from IDLE, with data available and the transmitter idle.
    assign w_pop = (r_state == IDLE) && !w_empty && tx_ready;

    uart_txq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    assign full     = w_full;
    assign empty    = w_empty;
    assign level    = w_level;
    assign busy     = (r_state != IDLE) || !w_empty;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;

    // Issue sequencer: pulse start with the head byte, then wait for ready to
    // fall (transmitter has registered start) and rise (frame finished).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_tx_start <= 1'b0;
            r_tx_data  <= {BYTE_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_head;
                        r_tx_start <= 1'b1;
                        r_state    <= ISSUE;
                    end else begin
                        r_tx_start <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_tx_start <= 1'b0;
                    r_state    <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    r_tx_start <= 1'b0;
                    if (!tx_ready) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    r_tx_start <= 1'b0;
                    if (tx_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVF_EN
    logic r_ovf;

    assign ovf = r_ovf;

    // Sticky overflow flag: any write while full sets it; set beats clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (wr_en && w_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= r_ovf;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural transmitter model
// (one clock per bit, LSB first) and a byte scoreboard.
module tb_uart_tx_queue;

    logic       clk;
    logic       rstn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
`ifdef UART_TXQ_OVF_EN
    logic       ovf;
    logic       ovf_clr;
`endif

    int errors = 0;
    int checks = 0;

    uart_tx_queue dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .busy     (busy),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready)
`ifdef UART_TXQ_OVF_EN
        ,
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- transmitter model ----------------
    // phase 0: idle (ready high); 1: start seen, ready still high for m_delay
    // cycles; 2: shifting 10 bits, ready low.
    logic       m_hold;
    int         m_delay;
    int         m_phase;
    int         m_cnt;
    int         m_bit;
    logic [7:0] m_sh;
    logic [9:0] m_ser;
    logic [9:0] m_last_ser = 10'd0;
    int         start_cnt  = 0;
    int         start_viol = 0;
    int         data_viol  = 0;
    logic [7:0] rx_q[$];
    logic       m_line;

    assign tx_ready = !m_hold && (m_phase != 2);

    always_comb begin
        if (m_bit == 0)      m_line = 1'b0;
        else if (m_bit >= 9) m_line = 1'b1;
        else                 m_line = m_sh[m_bit-1];
    end

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase <= 0;
            m_cnt   <= 0;
            m_bit   <= 0;
            m_sh    <= 8'd0;
            m_ser   <= 10'd0;
        end else if (tx_start) begin
            start_cnt <= start_cnt + 1;
            if (m_phase != 0 || m_hold) start_viol <= start_viol + 1;
            m_sh  <= tx_data;
            m_bit <= 0;
            if (m_delay > 0) begin
                m_phase <= 1;
                m_cnt   <= m_delay;
            end else begin
                m_phase <= 2;
            end
        end else if (m_phase == 1) begin
            if (m_cnt <= 1) m_phase <= 2;
            m_cnt <= m_cnt - 1;
        end else if (m_phase == 2) begin
            if (tx_data !== m_sh) data_viol <= data_viol + 1;
            m_ser[m_bit] <= m_line;
            if (m_bit == 9) begin
                m_phase    <= 0;
                m_last_ser <= {m_line, m_ser[8:0]};
                rx_q.push_back(m_sh);
            end else begin
                m_bit <= m_bit + 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy !== 1'b0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    // Compare bytes received since index 'from' against the expected list.
    task automatic check_rx(input string tag, input int from, input logic [7:0] want[$]);
        int n;
        chk({tag, "_count"}, rx_q.size() - from, want.size());
        n = rx_q.size() - from;
        if (n > want.size()) n = want.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[from+i]}, {24'd0, want[i]});
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam logic [9:0] A5_FRAME = 10'b1101001010;

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         rx_rd;
        int         snap;
        int         n;

        rstn    = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'd0;
        m_hold  = 1'b0;
        m_delay = 0;
`ifdef UART_TXQ_OVF_EN
        ovf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_level", {27'd0, level}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, tx_start}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
`ifdef UART_TXQ_OVF_EN
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif

        // Single byte: start pulse two cycles after the write
        wr(8'hA5);
        chk("single_lat1_start", {31'd0, tx_start}, 32'd0);
        chk("single_lat1_level", {27'd0, level}, 32'd1);
        @(negedge clk);
        chk("single_start", {31'd0, tx_start}, 32'd1);
        chk("single_data", {24'd0, tx_data}, 32'hA5);
        chk("single_empty", {31'd0, empty}, 32'd1);
        @(negedge clk);
        chk("single_pulse_end", {31'd0, tx_start}, 32'd0);
        wait_idle("single_idle", 100);
        exp_q = '{8'hA5};
        check_rx("single", 0, exp_q);
        chk("single_frame", {22'd0, m_last_ser}, {22'd0, A5_FRAME});
        chk("single_starts", start_cnt, 1);
        rx_rd = rx_q.size();

        // Burst 0x00..0x0F with the transmitter held off, then overflow
        m_hold = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            wr(b);
            exp_q.push_back(b);
        end
        chk("burst_full", {31'd0, full}, 32'd1);
        chk("burst_level", {27'd0, level}, 32'd16);
        wr(8'h77);
        chk("ovf_level", {27'd0, level}, 32'd16);
        chk("ovf_full", {31'd0, full}, 32'd1);
`ifdef UART_TXQ_OVF_EN
        chk("ovf_set", {31'd0, ovf}, 32'd1);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_cleared", {31'd0, ovf}, 32'd0);
        ovf_clr = 1'b1;
        wr(8'h77);
        ovf_clr = 1'b0;
        chk("ovf_set_wins", {31'd0, ovf}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
`endif
        snap = start_cnt;
        m_hold = 1'b0;
        wait_idle("burst_idle", 2000);
        check_rx("burst", rx_rd, exp_q);
        chk("burst_starts", start_cnt - snap, 16);
        rx_rd = rx_q.size();

        // Push and pop in the same cycle at full: write dropped
        m_hold = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            wr(b);
            exp_q.push_back(b);
        end
        chk("pp_full", {31'd0, full}, 32'd1);
        m_hold = 1'b0;
        wr(8'($urandom));
        chk("pp_level", {27'd0, level}, 32'd15);
        chk("pp_notfull", {31'd0, full}, 32'd0);
        chk("pp_start", {31'd0, tx_start}, 32'd1);
        wait_idle("pp_idle", 2000);
        check_rx("pp", rx_rd, exp_q);
        rx_rd = rx_q.size();

        // Random bursts of random length
        for (int rep = 0; rep < 3; rep++) begin
            m_hold = 1'b1;
            exp_q.delete();
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                wr(b);
                if (i < 16) exp_q.push_back(b);
            end
            chk($sformatf("rnd%0d_level", rep), {27'd0, level}, (n > 16) ? 16 : n);
            chk($sformatf("rnd%0d_full", rep), {31'd0, full}, (n >= 16) ? 1 : 0);
            m_hold = 1'b0;
            wait_idle($sformatf("rnd%0d_idle", rep), 3000);
            check_rx($sformatf("rnd%0d", rep), rx_rd, exp_q);
            rx_rd = rx_q.size();
        end

        // Ready stays high 2 cycles after start: no early re-issue
        m_delay = 2;
        exp_q.delete();
        snap = start_cnt;
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            wr(b);
            exp_q.push_back(b);
        end
        wait_idle("hs_idle", 500);
        check_rx("hs", rx_rd, exp_q);
        chk("hs_starts", start_cnt - snap, 3);
        rx_rd = rx_q.size();
        m_delay = 0;

        chk("no_start_viol", start_viol, 0);
        chk("tx_data_stable", data_viol, 0);

        // Reset mid-frame with 5 bytes queued
        for (int i = 0; i < 6; i++) wr(8'($urandom));
        chk("mid_level", {27'd0, level}, 32'd5);
        n = 0;
        while (tx_ready !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_ready_low", {31'd0, tx_ready}, 32'd0);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("mid_rst_start", {31'd0, tx_start}, 32'd0);
        chk("mid_rst_level", {27'd0, level}, 32'd0);
        chk("mid_rst_empty", {31'd0, empty}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        snap = start_cnt;
        repeat (60) @(negedge clk);
        chk("mid_no_starts", start_cnt - snap, 0);
        chk("mid_level_after", {27'd0, level}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
